// File: rtl/mdu_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int unsigned MDU_WIDTH = 32;
  localparam int unsigned MDU_ITERS = 32;
  localparam int unsigned MDU_CNT_W = $clog2(MDU_ITERS);

  typedef enum logic [1:0] {
    MDU_MULTU = 2'b00,
    MDU_MULT  = 2'b01,
    MDU_DIVU  = 2'b10,
    MDU_DIV   = 2'b11
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } mdu_state_t;

  // Magnitude of x when the operation is signed, x unchanged otherwise.
  function automatic logic [MDU_WIDTH-1:0] abs_sel(input logic [MDU_WIDTH-1:0] x,
                                                   input logic signed_op);
    return (signed_op && x[MDU_WIDTH-1]) ? (MDU_WIDTH'(0) - x) : x;
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit: 32 shift-add or restoring-divide steps,
// one sign-fix cycle, then a one-cycle done pulse that writes HI/LO.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = MDU_CNT_W;

  mdu_state_t       state, state_nx;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] acc_hi, acc_lo;
  logic [WIDTH-1:0] opnd;
  logic             is_div, neg_res, neg_rem, div0;

  mdu_op_t          op_dec;
  logic             signed_op, div_op;
  logic             load_c, step_c, write_c;
  logic [WIDTH-1:0] acc_hi_nx, acc_lo_nx;
  logic [WIDTH:0]   sum, shifted;
  logic [WIDTH-1:0] diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] res_hi, res_lo;

  assign op_dec    = mdu_op_t'(op);
  assign signed_op = (op_dec == MDU_MULT) || (op_dec == MDU_DIV);
  assign div_op    = (op_dec == MDU_DIVU) || (op_dec == MDU_DIV);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state; a flush beats both completion and a new request while in flight
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        if (cancel)                                state_nx = IDLE;
        else if (count == CNT_W'(MDU_ITERS - 1))   state_nx = FIX;
      end
      FIX:  state_nx = cancel ? IDLE : DONE;
      DONE: state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Control strobes, one iteration step and the sign-corrected result
  always_comb begin
    load_c    = start && ((state == IDLE) || (state == DONE));
    step_c    = (state == RUN);
    write_c   = (state == FIX) && !cancel;
    acc_hi_nx = acc_hi;
    acc_lo_nx = acc_lo;
    sum       = '0;
    shifted   = '0;
    diff      = '0;
    if (is_div) begin
      shifted = {acc_hi, acc_lo[WIDTH-1]};
      diff    = shifted[WIDTH-1:0] - opnd;
      if (shifted >= {1'b0, opnd}) begin
        acc_hi_nx = diff;
        acc_lo_nx = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        acc_hi_nx = shifted[WIDTH-1:0];
        acc_lo_nx = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : (WIDTH + 1)'(0));
      {acc_hi_nx, acc_lo_nx} = {sum, acc_lo[WIDTH-1:1]};
    end

    prod = {acc_hi, acc_lo};
    if (neg_res) prod = (2 * WIDTH)'(0) - prod;
    if (is_div) begin
      res_lo = div0 ? '1 : (neg_res ? (WIDTH'(0) - acc_lo) : acc_lo);
      res_hi = neg_rem ? (WIDTH'(0) - acc_hi) : acc_hi;
    end else begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      opnd    <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      busy <= (state_nx == RUN) || (state_nx == FIX);
      done <= write_c;
      if (load_c) begin
        count   <= '0;
        acc_hi  <= '0;
        acc_lo  <= abs_sel(a, signed_op);
        opnd    <= abs_sel(b, signed_op);
        is_div  <= div_op;
        neg_res <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_rem <= signed_op && a[WIDTH-1];
        div0    <= div_op && (b == '0);
      end else if (step_c) begin
        count  <= count + CNT_W'(1);
        acc_hi <= acc_hi_nx;
        acc_lo <= acc_lo_nx;
      end
      if (write_c) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed table, random ops against an
// arithmetic reference model, and hand-written flush/reset/overlap sequences.
module tb_mdu_iter;

  localparam int unsigned W = 32;
  localparam int LAT = 34;

  logic         clk = 1'b0;
  logic         reset, start, cancel;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  // Reference {hi, lo} from plain 64-bit arithmetic
  function automatic logic [63:0] mdu_model(input logic [1:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
    longint sx, sy, p, q, r;
    logic [63:0] u;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: begin u = {32'b0, x} * {32'b0, y}; return u; end
      2'b01: begin p = sx * sy; return 64'(p); end
      2'b10: begin
        if (y == 32'b0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      default: begin
        if (y == 32'b0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one request through a sampling edge, then scramble the operand pins
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  // Cycle index of the done pulse; the cycle right after the sampling edge is 1
  task automatic wait_done(input int from, output int lat);
    lat = from;
    while (!done && lat < 80) begin
      tick();
      lat++;
    end
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      tick();
      if (done) cnt++;
    end
  endtask

  task automatic run_check(input string name, input logic [1:0] o, input logic [31:0] x,
                           input logic [31:0] y, input logic [63:0] exp);
    int lat;
    issue(o, x, y);
    wait_done(1, lat);
    chk({name, "_lat"}, 64'(lat), 64'(LAT));
    chk({name, "_res"}, {hi, lo}, exp);
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom >> $urandom_range(0, 31);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    vec_t vecs[6];
    int lat, cnt;
    logic [63:0] prior;
    logic [1:0] ro;
    logic [31:0] ra, rb;

    vecs[0] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{2'b10, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[4] = '{2'b10, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF};
    vecs[5] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};

    reset = 1'b1; start = 1'b0; cancel = 1'b0; op = 2'b00; a = '0; b = '0;
    tick();
    start = 1'b1; cancel = 1'b1;
    tick();
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_hilo", {hi, lo}, 64'(0));
    reset = 1'b0; start = 1'b0; cancel = 1'b0;
    tick();

    // Directed table
    for (int i = 0; i < 6; i++) begin
      run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                {vecs[i].hi, vecs[i].lo});
      tick();
      chk($sformatf("vec%0d_pulse", i), 64'(done), 64'(0));
    end

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      ra = rand_opnd();
      rb = rand_opnd();
      run_check($sformatf("rnd%0d_op%0d_%h_%h", i, ro, ra, rb), ro, ra, rb,
                mdu_model(ro, ra, rb));
      if ($urandom_range(0, 1) == 1) tick();
    end
    tick();

    // Second start while busy is ignored
    issue(2'b00, 32'd1234, 32'd5678);
    repeat (3) tick();
    chk("busy_run", 64'(busy), 64'(1));
    op = 2'b10; a = 32'd99; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(5, lat);
    chk("ign_lat", 64'(lat), 64'(LAT));
    chk("ign_res", {hi, lo}, mdu_model(2'b00, 32'd1234, 32'd5678));

    // Start in the DONE cycle: next done follows 34 cycles later
    issue(2'b11, 32'hFFFF_FF00, 32'd9);
    wait_done(1, lat);
    chk("b2b_first", {hi, lo}, mdu_model(2'b11, 32'hFFFF_FF00, 32'd9));
    issue(2'b01, 32'h1234_5678, 32'h8765_4321);
    wait_done(1, lat);
    chk("b2b_lat", 64'(lat), 64'(LAT));
    chk("b2b_res", {hi, lo}, mdu_model(2'b01, 32'h1234_5678, 32'h8765_4321));
    tick();

    // Flush in RUN around cycle 10
    prior = {hi, lo};
    issue(2'b10, 32'd1000, 32'd3);
    repeat (8) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel_busy", 64'(busy), 64'(0));
    count_done(45, cnt);
    chk("cancel_no_done", 64'(cnt), 64'(0));
    chk("cancel_hilo", {hi, lo}, prior);

    // Flush in FIX together with a start: flush wins, start dropped
    issue(2'b01, 32'd77, 32'hFFFF_FFFE);
    repeat (32) tick();
    chk("fix_busy", 64'(busy), 64'(1));
    chk("fix_no_done", 64'(done), 64'(0));
    cancel = 1'b1; start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd5;
    tick();
    cancel = 1'b0; start = 1'b0;
    chk("fixcan_busy", 64'(busy), 64'(0));
    count_done(45, cnt);
    chk("fixcan_no_done", 64'(cnt), 64'(0));
    chk("fixcan_hilo", {hi, lo}, prior);

    // Start and cancel together in IDLE: start wins
    op = 2'b11; a = 32'hFFFF_FF9C; b = 32'd7; start = 1'b1; cancel = 1'b1;
    tick();
    start = 1'b0; cancel = 1'b0;
    wait_done(1, lat);
    chk("idlecan_lat", 64'(lat), 64'(LAT));
    chk("idlecan_res", {hi, lo}, mdu_model(2'b11, 32'hFFFF_FF9C, 32'd7));
    tick();

    // Reset mid-operation
    issue(2'b00, 32'd3, 32'd4);
    repeat (18) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_hilo", {hi, lo}, 64'(0));
    count_done(45, cnt);
    chk("rst_no_done", 64'(cnt), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
